seq_bit_serializer: RTL and testbench
=====================================

Name: seq_bit_serializer

Overview:
- Upstream feeder for the serial sequence-detector stage.
- Accepts parallel WIDTH-bit words over a valid/ready handshake and streams them out one bit per clock on a serial line `x`, with `x_valid` qualifying each bit.
- A one-word holding buffer allows gapless back-to-back streaming.

Parameters:
WIDTH, 8, word width in bits; legal range WIDTH >= 2.
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = bit 0 first.
IDLE_BIT, 0, value driven on x whenever x_valid = 0.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  reset, asynchronous, active-high.
din  input  WIDTH  parallel word to serialize.
din_valid  input  1  din holds a word to transfer.
din_ready  output  1  block can accept a word this cycle.
x  output  1  serial bit stream to the downstream detector.
x_valid  output  1  x carries a real data bit this cycle.
word_done  output  1  pulse; x carries the last bit of a word this cycle.
busy  output  1  shifting, or holding buffer occupied.

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values:
  - state = IDLE; shift register, bit counter, hold register and hold_full all cleared.
  - x = IDLE_BIT; x_valid = 0; word_done = 0; busy = 0; din_ready = 1.
- Reset mid-word discards the shift and hold contents. No partial word resumes.
- All outputs are driven from registers or decoded from state/counter only. No combinational path from din or din_valid to any output.
- Transfer rule: a word transfers on a rising edge where din_valid && din_ready.
- din_ready = !hold_full.
- States: IDLE, SHIFT.
- IDLE:
  - x_valid = 0; x = IDLE_BIT.
  - On transfer: load the shift register from din, cnt = 0, go to SHIFT.
  - Latency: the first bit appears on x in the cycle immediately after the accepting edge.
- SHIFT:
  - x_valid = 1.
  - x = current head bit: sh[WIDTH-1] when MSB_FIRST, sh[0] otherwise.
  - Each edge shifts by one and increments cnt.
  - Mid-word transfer: while cnt != WIDTH-1, an accepted word goes to the hold register and hold_full is set.
- Last-bit cycle (cnt == WIDTH-1): word_done = 1. At the closing edge, in priority order:
  - (a) hold_full = 1: load shift register from hold, clear hold_full, cnt = 0, stay in SHIFT.
  - (b) hold_full = 0 and a transfer occurs on this edge: load shift register directly from din (bypass), cnt = 0, stay in SHIFT.
  - (c) otherwise: go to IDLE.
  - In cases (a) and (b), x_valid stays 1 with no gap cycle.
- In case (a), din_ready was 0 during that cycle, so no new word can arrive on the same edge. hold_full never overflows.
- busy = (state == SHIFT) || hold_full.
- cnt width is $clog2(WIDTH). cnt never exceeds WIDTH-1 and resets to 0 on every load.
- din is sampled only on the accepting edge. Changes to din at other times have no effect.
- din_valid may drop without a transfer. No state change results.

Test Plan:
1. Single word, WIDTH=8, MSB_FIRST=1, din=8'b1010_0000, valid one cycle:
   - x = 1,0,1,0,0,0,0,0 over 8 consecutive cycles, x_valid high exactly 8 cycles.
   - word_done high only on the 8th cycle, then x = IDLE_BIT and busy = 0.
2. Back-to-back, din_valid held high with 8'hA5 then 8'h3C:
   - 16 consecutive x_valid cycles with bits 10100101 00111100.
   - din_ready low from the edge after 8'h3C is held until its load into the shift register.
   - word_done high on cycles 8 and 16.
3. MSB_FIRST=0, din=8'h0D: x = 1,0,1,1,0,0,0,0.
4. Bypass: hold empty, din_valid rises exactly on the last-bit cycle of the first word with 8'hF0:
   - Next cycle x = 1 with x_valid still high (no gap).
   - hold_full stays 0.
5. Backpressure: third word presented while hold_full = 1:
   - Not accepted (din_ready = 0).
   - Accepted on the first edge where din_ready = 1.
   - The word's bits appear exactly once and in order.
6. Assert rst during bit 4 of a word with hold_full = 1:
   - Immediately x_valid = 0, busy = 0, din_ready = 1, x = IDLE_BIT.
   - After release, a new word 8'h81 streams 1,0,0,0,0,0,0,1 with no residue of the old words.

Source files
------------

// File: rtl/seq_bit_serializer_if.sv
// Parallel-word handshake and serial-stream bundle for the bit serializer.
// The master side feeds words; the slave side (the serializer) drives the stream.
interface seq_bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             x;
  logic             x_valid;
  logic             word_done;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, x, x_valid, word_done, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, x, x_valid, word_done, busy
  );
endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder: one bit per clock on x, with a one-word hold buffer
// so consecutive words stream without a gap cycle.
module seq_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input logic              clk,
  input logic              rst,
  seq_bit_serializer_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] hold;
  logic [CNT_W-1:0] cnt;
  logic             hold_full;

  logic             xfer;
  logic             last_bit;
  logic             head;
  logic [WIDTH-1:0] sh_next;

  assign xfer     = bus.din_valid && !hold_full;
  assign last_bit = (cnt == LAST_CNT);
  assign head     = MSB_FIRST ? sh[WIDTH-1] : sh[0];
  assign sh_next  = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sh        <= '0;
      hold      <= '0;
      cnt       <= '0;
      hold_full <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            sh    <= bus.din;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (!last_bit) begin
            sh  <= sh_next;
            cnt <= cnt + 1'b1;
            if (xfer) begin
              hold      <= bus.din;
              hold_full <= 1'b1;
            end
          end else if (hold_full) begin
            // din_ready is low here, so no new word can collide with the reload
            sh        <= hold;
            hold_full <= 1'b0;
            cnt       <= '0;
          end else if (xfer) begin
            sh  <= bus.din;
            cnt <= '0;
          end else begin
            sh    <= '0;
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // All outputs decode from registered state only; din never reaches them.
  assign bus.din_ready = !hold_full;
  assign bus.x_valid   = (state == SHIFT);
  assign bus.x         = (state == SHIFT) ? head : IDLE_BIT;
  assign bus.word_done = (state == SHIFT) && last_bit;
  assign bus.busy      = (state == SHIFT) || hold_full;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: MSB-first and LSB-first instances share stimulus
// and are checked every cycle against a bit-queue model plus literal expectations.
module tb_seq_bit_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Model: queue of bits still owed on x; front is what x shows this cycle.
  bit qa[$];
  bit qb[$];
  bit acc_m;

  seq_bit_serializer_if #(.WIDTH(W)) bus_a ();
  seq_bit_serializer_if #(.WIDTH(W)) bus_b ();

  assign bus_a.din       = din;
  assign bus_a.din_valid = din_valid;
  assign bus_b.din       = din;
  assign bus_b.din_valid = din_valid;

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d);
    din_valid = v;
    din       = d;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      acc_m = din_valid && (qa.size() <= W);
      if (qa.size() > 0) void'(qa.pop_front());
      if (qb.size() > 0) void'(qb.pop_front());
      if (acc_m) begin
        for (int i = 0; i < W; i++) begin
          qa.push_back(din[W-1-i]);
          qb.push_back(din[i]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("m_a_xv",   bus_a.x_valid,   qa.size() > 0);
      chk("m_a_x",    bus_a.x,         (qa.size() > 0) ? qa[0] : 1'b0);
      chk("m_a_wd",   bus_a.word_done, (qa.size() % W) == 1);
      chk("m_a_busy", bus_a.busy,      qa.size() > 0);
      chk("m_a_rdy",  bus_a.din_ready, qa.size() <= W);
      chk("m_b_xv",   bus_b.x_valid,   qb.size() > 0);
      chk("m_b_x",    bus_b.x,         (qb.size() > 0) ? qb[0] : 1'b0);
      chk("m_b_wd",   bus_b.word_done, (qb.size() % W) == 1);
      chk("m_b_rdy",  bus_b.din_ready, qb.size() <= W);
    end
  end

  initial begin
    logic [7:0]  w;
    logic [15:0] s16;
    logic [23:0] s24;

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_x",   bus_a.x,         1'b0);
    chk("rst_xv",  bus_a.x_valid,   1'b0);
    chk("rst_wd",  bus_a.word_done, 1'b0);
    chk("rst_bsy", bus_a.busy,      1'b0);
    chk("rst_rdy", bus_a.din_ready, 1'b1);
    rst = 1'b0;
    check_en = 1'b1;

    // single word, MSB first
    w = 8'b1010_0000;
    @(negedge clk); drive(1'b1, w);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) drive(1'b0, 8'h5A);
      chk("t1_x",  bus_a.x, w[7-i]);
      chk("t1_xv", bus_a.x_valid, 1'b1);
      chk("t1_wd", bus_a.word_done, i == 7);
    end
    @(negedge clk);
    chk("t1_idle_x",  bus_a.x, 1'b0);
    chk("t1_idle_xv", bus_a.x_valid, 1'b0);
    chk("t1_idle_bs", bus_a.busy, 1'b0);

    // back-to-back through the hold register
    s16 = '0;
    @(negedge clk); drive(1'b1, 8'hA5);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) drive(1'b1, 8'h3C);
      if (i == 2) drive(1'b0, 8'h00);
      s16 = {s16[14:0], bus_a.x};
      chk("t2_xv", bus_a.x_valid, 1'b1);
      chk("t2_wd", bus_a.word_done, (i == 8) || (i == 16));
      if (i >= 2 && i <= 8) chk("t2_rdy_lo", bus_a.din_ready, 1'b0);
      if (i == 1 || i == 9) chk("t2_rdy_hi", bus_a.din_ready, 1'b1);
    end
    chk("t2_bits", s16, 16'hA53C);
    @(negedge clk);

    // LSB first on the second instance
    w = 8'h0D;
    @(negedge clk); drive(1'b1, w);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) drive(1'b0, 8'h00);
      chk("t3_x", bus_b.x, w[i]);
    end
    @(negedge clk);

    // bypass: next word arrives exactly on the last-bit cycle
    @(negedge clk); drive(1'b1, 8'h0F);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 8) begin
        chk("t4_rdy_last", bus_a.din_ready, 1'b1);
        chk("t4_wd_last",  bus_a.word_done, 1'b1);
      end
      if (i == 9) begin
        chk("t4_x",   bus_a.x, 1'b1);
        chk("t4_xv",  bus_a.x_valid, 1'b1);
        chk("t4_rdy", bus_a.din_ready, 1'b1);
      end
      if (i == 1) drive(1'b0, 8'h00);
      if (i == 8) drive(1'b1, 8'hF0);
      if (i == 9) drive(1'b0, 8'h00);
    end
    repeat (8) @(negedge clk);

    // backpressure: third word waits for din_ready
    s24 = '0;
    @(negedge clk); drive(1'b1, 8'h11);
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      s24 = {s24[22:0], bus_a.x};
      if (i >= 2 && i <= 8) chk("t5_rdy_lo", bus_a.din_ready, 1'b0);
      if (i == 9)  chk("t5_rdy_hi", bus_a.din_ready, 1'b1);
      if (i == 10) chk("t5_rdy_hold", bus_a.din_ready, 1'b0);
      if (i == 1)  drive(1'b1, 8'h22);
      if (i == 2)  drive(1'b1, 8'hC3);
      if (i == 10) drive(1'b0, 8'h00);
    end
    chk("t5_bits", s24, 24'h1122C3);
    @(negedge clk);
    chk("t5_idle", bus_a.busy, 1'b0);

    // reset mid-word with the hold register full
    @(negedge clk); drive(1'b1, 8'h55);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 2) chk("t6_hold", bus_a.din_ready, 1'b0);
      if (i == 1) drive(1'b1, 8'hAA);
      if (i == 2) drive(1'b0, 8'h00);
    end
    #2 rst = 1'b1;
    #1;
    chk("t6_xv",  bus_a.x_valid, 1'b0);
    chk("t6_bsy", bus_a.busy, 1'b0);
    chk("t6_rdy", bus_a.din_ready, 1'b1);
    chk("t6_x",   bus_a.x, 1'b0);
    @(negedge clk); rst = 1'b0;
    w = 8'h81;
    @(negedge clk); drive(1'b1, w);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) drive(1'b0, 8'hFF);
      chk("t6_x_new", bus_a.x, w[7-i]);
      chk("t6_xv_new", bus_a.x_valid, 1'b1);
    end
    @(negedge clk);
    chk("t6_done", bus_a.x_valid, 1'b0);

    // randomized traffic with varying load and occasional resets
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      if (n < 1500)
        drive($urandom_range(0, 3) != 0, W'($urandom));
      else
        drive($urandom_range(0, 3) == 0, W'($urandom));
    end
    drive(1'b0, 8'h00);
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
